// File: rtl/mips_pkg.sv
// Shared definitions for the sequential multiply/divide unit: data width,
// operation encodings and FSM state names.
package mips_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_e;

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// Request/result bundle between the pipeline (master) and the multiply/divide
// unit (slave).
interface mdu_seq_if;
    import mips_pkg::*;

    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic            mthi;
    logic            mtlo;
    logic [XLEN-1:0] wr_data;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            busy;
    logic            done;
    logic            div_zero;

    modport master (
        output start, op, rs_data, rt_data, mthi, mtlo, wr_data,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start, op, rs_data, rt_data, mthi, mtlo, wr_data,
        output hi, lo, busy, done, div_zero
    );

endinterface

// File: rtl/cond_neg.sv
// Conditional two's-complement: passes din through, or negates it when neg=1.
module cond_neg
    import mips_pkg::*;
(
    input  logic [XLEN-1:0] din,
    input  logic            neg,
    output logic [XLEN-1:0] dout
);

    assign dout = neg ? (~din + XLEN'(1)) : din;

endmodule

// File: rtl/mdu_seq.sv
// Sequential MIPS multiply/divide unit: one radix-2 step per cycle on operand
// magnitudes, sign fix-up afterwards, results land in the HI/LO registers.
module mdu_seq
    import mips_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    mdu_seq_if.slave bus
);

    state_e          state;
    op_e             op_in, op_q;
    logic [5:0]      count;
    logic            sign_a, sign_b, div0_q;
    logic            busy_q, done_q, div_zero_q;
    logic [XLEN-1:0] hi_q, lo_q;
    logic [XLEN-1:0] opnd, acc_hi, acc_lo;
    logic [XLEN-1:0] mag_a, mag_b, fix_hi, fix_lo, res_hi, res_lo, div_diff;
    logic [XLEN:0]   mul_sum, rem_shift;
    logic            div_ge, prod_neg, in_signed;

    assign op_in     = op_e'(bus.op);
    assign in_signed = op_is_signed(op_in);
    assign prod_neg  = sign_a ^ sign_b;

    cond_neg u_mag_a (.din(bus.rs_data), .neg(in_signed & bus.rs_data[XLEN-1]), .dout(mag_a));
    cond_neg u_mag_b (.din(bus.rt_data), .neg(in_signed & bus.rt_data[XLEN-1]), .dout(mag_b));

    // Quotient and product share the sign rule; the remainder follows the dividend.
    cond_neg u_fix_lo (.din(acc_lo), .neg(prod_neg), .dout(fix_lo));
    cond_neg u_fix_hi (.din(acc_hi), .neg(op_is_div(op_q) ? sign_a : prod_neg), .dout(fix_hi));

    // Multiply: {acc_hi, acc_lo} is the product/multiplier shift pair.
    // Divide:   acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign rem_shift = {acc_hi, acc_lo[XLEN-1]};
    assign div_ge    = rem_shift >= {1'b0, opnd};
    assign div_diff  = rem_shift[XLEN-1:0] - opnd;

    // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        res_hi = fix_hi;
        res_lo = fix_lo;
        if (op_is_div(op_q)) begin
            if (div0_q)
                res_lo = '1;
        end else if (prod_neg && (acc_lo != '0)) begin
            // 64-bit negate from 32-bit halves: no carry into HI unless LO is zero.
            res_hi = fix_hi - XLEN'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            op_q       <= OP_MULT;
            count      <= '0;
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            div0_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            opnd       <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.mthi) hi_q <= bus.wr_data;
                    if (bus.mtlo) lo_q <= bus.wr_data;
                    if (bus.start) begin
                        state      <= CALC;
                        busy_q     <= 1'b1;
                        op_q       <= op_in;
                        count      <= '0;
                        sign_a     <= in_signed & bus.rs_data[XLEN-1];
                        sign_b     <= in_signed & bus.rt_data[XLEN-1];
                        div0_q     <= op_is_div(op_in) && (bus.rt_data == '0);
                        div_zero_q <= 1'b0;
                        acc_hi     <= '0;
                        opnd       <= op_is_div(op_in) ? mag_b : mag_a;
                        acc_lo     <= op_is_div(op_in) ? mag_a : mag_b;
                    end
                end
                CALC: begin
                    if (op_is_div(op_q)) begin
                        acc_hi <= div_ge ? div_diff : rem_shift[XLEN-1:0];
                        acc_lo <= {acc_lo[XLEN-2:0], div_ge};
                    end else begin
                        acc_hi <= mul_sum[XLEN:1];
                        acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
                    end
                    count <= count + 6'd1;
                    if (count == 6'd31)
                        state <= FIX;
                end
                FIX: begin
                    hi_q       <= res_hi;
                    lo_q       <= res_lo;
                    div_zero_q <= div0_q;
                    done_q     <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed vectors, hand-written corner
// sequences and randomized operations against a plain-arithmetic model.
module tb_mdu_seq;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    mdu_seq_if bus ();

    mdu_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural result computed directly from the MIPS definitions.
    function automatic void ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        int          sa, sb;
        longint      p;
        logic [63:0] pu;
        sa = a;
        sb = b;
        dz = 1'b0;
        hi = '0;
        lo = '0;
        case (op)
            OP_MULT: begin
                p = longint'(sa) * longint'(sb);
                {hi, lo} = p;
            end
            OP_MULTU: begin
                pu = {32'b0, a} * {32'b0, b};
                {hi, lo} = pu;
            end
            default: begin
                if (b == 32'd0) begin
                    lo = 32'hFFFF_FFFF;
                    hi = a;
                    dz = 1'b1;
                end else if (op == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000;
                    hi = 32'd0;
                end else if (op == OP_DIV) begin
                    lo = sa / sb;
                    hi = sa % sb;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.op      = op;
        bus.rs_data = a;
        bus.rt_data = b;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.rs_data = $urandom;
        bus.rt_data = $urandom;
    endtask

    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (bus.done !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        int lat;
        launch(op, a, b);
        check({tag, ".busy"}, 64'(bus.busy), 64'd1);
        wait_done(0, lat);
        check({tag, ".latency"}, 64'(lat), 64'd33);
        hi = bus.hi;
        lo = bus.lo;
        dz = bus.div_zero;
        @(negedge clk);
        check({tag, ".done_pulse"}, {62'd0, bus.done, bus.busy}, 64'd0);
    endtask

    initial begin
        logic [31:0] hi, lo, ehi, elo, a, b;
        logic        dz, edz, seen_done;
        logic [1:0]  op;
        int          lat;

        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.op      = '0;
        bus.rs_data = '0;
        bus.rt_data = '0;
        bus.mthi    = 1'b0;
        bus.mtlo    = 1'b0;
        bus.wr_data = '0;

        vecs.push_back('{OP_MULT,  32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0});
        vecs.push_back('{OP_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0});
        vecs.push_back('{OP_DIV,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0});
        vecs.push_back('{OP_DIVU,  32'd7,          32'd2,         32'd1,         32'd3,         1'b0});
        vecs.push_back('{OP_DIVU,  32'd100,        32'd0,         32'h0000_0064, 32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{OP_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0});
        vecs.push_back('{OP_DIV,   32'hFFFF_FF9C,  32'd0,         32'hFFFF_FF9C, 32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{OP_MULT,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0});
        vecs.push_back('{OP_DIV,   32'd7,          32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0});
        vecs.push_back('{OP_MULT,  32'h0001_0000,  32'hFFFF_0000, 32'hFFFF_FFFF, 32'd0,         1'b0});
        vecs.push_back('{OP_MULT,  32'h0001_0000,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_0000, 1'b0});
        vecs.push_back('{OP_MULTU, 32'h8000_0000,  32'd2,         32'd1,         32'd0,         1'b0});

        // Reset values
        #12;
        check("reset.outputs", {bus.hi, bus.lo}, 64'd0);
        check("reset.flags", {61'd0, bus.busy, bus.done, bus.div_zero}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Direct moves in IDLE, single and together
        @(negedge clk);
        bus.mthi = 1'b1; bus.wr_data = 32'h1111_1111;
        @(negedge clk);
        bus.mthi = 1'b0;
        check("mthi.idle", {bus.hi, bus.lo}, {32'h1111_1111, 32'd0});
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wr_data = 32'h2222_2222;
        @(negedge clk);
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        check("mthi_mtlo.both", {bus.hi, bus.lo}, {32'h2222_2222, 32'h2222_2222});

        // Directed vector table
        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, hi, lo, dz);
            check($sformatf("vec%0d.hilo", i), {hi, lo}, {vecs[i].hi, vecs[i].lo});
            check($sformatf("vec%0d.div_zero", i), 64'(dz), 64'(vecs[i].dz));
        end

        // div_zero held until the next accepted start, then cleared
        run_op("dz_set", OP_DIVU, 32'd100, 32'd0, hi, lo, dz);
        repeat (3) @(negedge clk);
        check("dz.held", 64'(bus.div_zero), 64'd1);
        launch(OP_MULTU, 32'd1, 32'd1);
        check("dz.cleared", 64'(bus.div_zero), 64'd0);
        wait_done(0, lat);
        check("dz.next_result", {bus.hi, bus.lo}, 64'd1);
        @(negedge clk);

        // Move and start together: move lands first, result overwrites later
        @(negedge clk);
        bus.op = OP_MULTU; bus.rs_data = 32'd2; bus.rt_data = 32'd3;
        bus.start = 1'b1; bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wr_data = 32'hCAFE_F00D;
        @(negedge clk);
        bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
        check("move_start.move", {bus.hi, bus.lo}, {32'hCAFE_F00D, 32'hCAFE_F00D});
        wait_done(0, lat);
        check("move_start.result", {bus.hi, bus.lo}, {32'd0, 32'd6});
        @(negedge clk);

        // Restart and mthi while busy are ignored
        launch(OP_MULT, 32'd3, 32'd5);
        repeat (5) @(negedge clk);
        bus.start = 1'b1; bus.op = OP_DIVU; bus.rs_data = 32'd100; bus.rt_data = 32'd7;
        bus.mthi = 1'b1; bus.wr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.start = 1'b0; bus.mthi = 1'b0;
        check("busy.mthi_ignored", 64'(bus.hi), 64'd0);
        wait_done(6, lat);
        check("busy.latency", 64'(lat), 64'd33);
        check("busy.first_result", {bus.hi, bus.lo}, {32'd0, 32'd15});
        repeat (3) @(negedge clk);
        check("busy.no_queue", {62'd0, bus.busy, bus.done}, 64'd0);

        // Reset in the middle of CALC
        launch(OP_MULT, 32'h1234_5678, 32'h0000_0ABC);
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort.outputs", {bus.hi, bus.lo}, 64'd0);
        check("abort.flags", {61'd0, bus.busy, bus.done, bus.div_zero}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen_done = 1'b1;
        end
        check("abort.no_done", 64'(seen_done), 64'd0);
        check("abort.hilo_kept", {bus.hi, bus.lo}, 64'd0);
        run_op("after_abort", OP_MULT, 32'd7, 32'hFFFF_FFFD, hi, lo, dz);
        check("after_abort.hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       a = 32'h8000_0000;
                1, 2:    a = 32'($urandom_range(0, 20)) - 32'd10;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2, 3:    b = 32'($urandom_range(0, 20)) - 32'd10;
                default: b = $urandom;
            endcase
            ref_model(op, a, b, ehi, elo, edz);
            run_op($sformatf("rnd%0d", i), op, a, b, hi, lo, dz);
            check($sformatf("rnd%0d.hilo op=%0d a=%h b=%h", i, op, a, b), {hi, lo}, {ehi, elo});
            check($sformatf("rnd%0d.div_zero", i), 64'(dz), 64'(edz));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL: start  input  1  launch request, sampled only in IDLE.
REQ-004 SHALL: op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL: rs_data  input  32  operand A (multiplicand/dividend), taken from register-file dataOut1.
REQ-006 SHALL: rt_data  input  32  operand B (multiplier/divisor), taken from register-file dataOut2.
REQ-007 SHALL: mthi, mtlo  input  1 each  direct HI/LO write strobes.
REQ-008 SHALL: wr_data  input  32  data for mthi/mtlo.
REQ-009 SHALL: hi, lo  output  32 each  architectural HI/LO, feeding the register-file write_back path via MFHI/MFLO.
REQ-010 SHALL: busy  output  1  high whenever state != IDLE.
REQ-011 SHALL: done  output  1  one-cycle pulse; hi/lo hold the new result in that cycle.
REQ-012 SHALL: div_zero  output  1  set by a DIV/DIVU with rt_data==0; held until the next accepted start.

Function
REQ-013 SHALL: FSM states IDLE, CALC, FIX, DONE; IDLE->CALC on start; CALC->FIX after 32 iterations; FIX->DONE; DONE->IDLE unconditionally.
REQ-014 SHALL: on acceptance (edge E0), latch op, |A|, |B| (magnitudes for signed ops, raw values for unsigned ops), result signs, and clear the 6-bit iteration counter.
REQ-015 SHALL: CALC performs one radix-2 step per cycle: shift-add for multiply (64-bit product), restoring division for divide (32-bit quotient and remainder).
REQ-016 SHALL: FIX negates as required: signed product by sign(A)^sign(B); quotient by sign(A)^sign(B); remainder by sign(A).
REQ-017 SHALL: hi/lo are written on the FIX->DONE edge (E33); multiply gives hi=product[63:32], lo=product[31:0]; divide gives lo=quotient, hi=remainder.
REQ-018 SHALL: done is high for exactly the cycle after E33; busy covers E0+1 through the DONE cycle inclusive.
REQ-019 SHALL: start while busy is ignored (no queuing, no effect on the operation in flight).
REQ-020 SHALL: divide by zero gives lo=32'hFFFFFFFF and hi=rs_data (unmodified), with div_zero=1 at done; timing is unchanged (34 cycles).
REQ-021 SHALL: signed -2^31 / -1 gives lo=32'h80000000 and hi=0; no flag is raised.
REQ-022 SHALL: mthi/mtlo write hi/lo in IDLE only and are ignored while busy.
REQ-023 SHALL: when mthi/mtlo and start coincide in IDLE, the move writes first and the operation result later overwrites it.
REQ-024 SHALL: when mthi and mtlo are both asserted, both registers receive wr_data.
REQ-025 SHALL: operands are sampled only at E0; later changes to rs_data/rt_data have no effect.

Reset
REQ-026 SHALL: reset, at any time including mid-CALC, forces IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, and counter=0.
REQ-027 SHALL: an aborted operation never asserts done or updates hi/lo after reset deasserts.

Structure
REQ-028 SHALL: package mips_pkg holds the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), the state enum, and XLEN=32.
REQ-029 SHALL: the single sub-module cond_neg (32-bit, conditional two's-complement) is used for operand magnitude and for result sign fix.

Verification
REQ-030 SHALL: MULT 7 x 32'hFFFFFFFD -> hi=FFFFFFFF, lo=FFFFFFEB, done exactly one cycle after E33.
REQ-031 SHALL: MULTU FFFFFFFF x FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
REQ-032 SHALL: DIV -7 / 2 -> lo=FFFFFFFD, hi=FFFFFFFF; DIVU 7 / 2 -> lo=3, hi=1.
REQ-033 SHALL: DIVU 100 / 0 -> lo=FFFFFFFF, hi=00000064, div_zero=1; div_zero clears on the next start.
REQ-034 SHALL: start MULT, re-pulse start with new operands at cycle 5 -> result of the first operation only; mthi during busy -> hi unchanged.
REQ-035 SHALL: reset asserted at CALC cycle 10 -> outputs zero immediately, no done pulse; a new MULT afterwards completes normally.
